// File: rtl/dram_image_pkg.sv
// Shared constants and state encoding for the dramImage access sequencers.
package dram_image_pkg;

  localparam int LANES = 10;
  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int LIW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Address of lane ofs within a group starting at base; wraps modulo 2^AW.
  function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] base,
                                              input logic [LIW-1:0] ofs);
    return base + {{(AW-LIW){1'b0}}, ofs};
  endfunction

endpackage

// File: rtl/dram_image_wr_ctrl.sv
// Write sequencer for dramImage: packs a pixel stream into groups of LANES
// and issues one all-lane write per group.
module dram_image_wr_ctrl
  import dram_image_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW:0]           pix_count,
  input  logic                  abort,
  input  logic                  px_valid,
  input  logic [DW-1:0]         px_data,
  output logic                  px_ready,
  output logic                  mem_we,
  output logic [LANES*AW-1:0]   mem_a,
  output logic [LANES*DW-1:0]   mem_wd,
  output logic                  busy,
  output logic                  done
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [AW-1:0]       r_grp_addr;
  logic [AW:0]         r_remaining;
  logic [LIW-1:0]      r_lane_idx;
  logic [DW-1:0]       r_lane_buf [LANES];

  logic                r_mem_we;
  logic                r_px_ready;
  logic                r_busy;
  logic                r_done;
  logic [LANES*AW-1:0] r_mem_a;
  logic [LANES*DW-1:0] r_mem_wd;

  logic                w_xfer;
  logic                w_last;
  logic [LANES*AW-1:0] w_wr_a;
  logic [LANES*DW-1:0] w_wr_d;

  assign w_xfer = r_px_ready & px_valid;
  assign w_last = w_xfer & ((r_lane_idx == LIW'(LANES-1)) |
                            (r_remaining == {{AW{1'b0}}, 1'b1}));

  // Next-state decision for the job sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (pix_count == {(AW+1){1'b0}}) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (r_remaining == {(AW+1){1'b0}}) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Lane image for the closing transfer; the incoming pixel is the last filled
  // lane, and every lane beyond it repeats that pixel and its address.
  always_comb begin
    w_wr_a = {(LANES*AW){1'b0}};
    w_wr_d = {(LANES*DW){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      if (LIW'(k) < r_lane_idx) begin
        w_wr_a[AW*k +: AW] = lane_addr(r_grp_addr, LIW'(k));
        w_wr_d[DW*k +: DW] = r_lane_buf[k];
      end else begin
        w_wr_a[AW*k +: AW] = lane_addr(r_grp_addr, r_lane_idx);
        w_wr_d[DW*k +: DW] = px_data;
      end
    end
  end

  // Sequencer state, lane buffer, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grp_addr  <= {AW{1'b0}};
      r_remaining <= {(AW+1){1'b0}};
      r_lane_idx  <= {LIW{1'b0}};
      for (int k = 0; k < LANES; k++) begin
        r_lane_buf[k] <= {DW{1'b0}};
      end
      r_mem_we    <= 1'b0;
      r_px_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_a     <= {(LANES*AW){1'b0}};
      r_mem_wd    <= {(LANES*DW){1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_px_ready <= (w_state_nxt == ST_FILL);
      r_mem_we   <= (w_state_nxt == ST_WRITE);
      r_done     <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_grp_addr  <= base_addr;
            r_remaining <= pix_count;
            r_lane_idx  <= {LIW{1'b0}};
          end
        end
        ST_FILL: begin
          if (w_xfer && !abort) begin
            r_lane_buf[r_lane_idx] <= px_data;
            r_lane_idx             <= r_lane_idx + LIW'(1);
            r_remaining            <= r_remaining - {{AW{1'b0}}, 1'b1};
            if (w_last) begin
              r_mem_a  <= w_wr_a;
              r_mem_wd <= w_wr_d;
            end
          end
        end
        ST_WRITE: begin
          r_grp_addr <= r_grp_addr + AW'(LANES);
          r_lane_idx <= {LIW{1'b0}};
        end
        ST_DONE: begin
          r_lane_idx <= {LIW{1'b0}};
        end
        default: begin
          r_lane_idx <= {LIW{1'b0}};
        end
      endcase
    end
  end

  assign mem_we   = r_mem_we;
  assign px_ready = r_px_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_a    = r_mem_a;
  assign mem_wd   = r_mem_wd;

endmodule

// File: doc/dram_image_wr_ctrl.md
Name: dram_image_wr_ctrl

Overview:
Write sequencer for the 10-port image DRAM (dramImage). It accepts a job (base address, pixel count) and a valid/ready stream of 16-bit pixels, and packs consecutive pixels into the 10 write lanes. It issues one single-cycle, all-lane write per group of 10 pixels. It sits between the image loader/processing datapath and dramImage, and is the only driver of its we, a1..a10 and wd1..wd10.

Parameters:
LANES, 10, number of DRAM write lanes (fixed by dramImage)
AW, 18, DRAM address width
DW, 16, pixel/data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  job request; accepted only when busy=0
base_addr  in  AW  first pixel address of job
pix_count  in  AW+1  pixels in job, 0..2^AW
abort  in  1  synchronous job cancel
px_valid  in  1  pixel data valid
px_data  in  DW  pixel value
px_ready  out  1  controller can accept pixel
mem_we  out  1  to dramImage we
mem_a  out  LANES*AW  lane k address at [AW*k+AW-1:AW*k]; lane 0 drives a1
mem_wd  out  LANES*DW  lane k data at [DW*k+DW-1:DW*k]; lane 0 drives wd1
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset: state=IDLE; mem_we, px_ready, busy, done = 0; mem_a, mem_wd, lane buffer, counters = 0.
- States: IDLE, FILL, WRITE, DONE; mem_we=(state==WRITE), px_ready=(state==FILL), busy=(state!=IDLE); all from registers, no combinational input-to-output paths.
- IDLE: on start, latch grp_addr=base_addr, remaining=pix_count, lane_idx=0. If pix_count==0 go to DONE, otherwise go to FILL.
- FILL: on px_valid&&px_ready, store px_data in lane[lane_idx], set lane_idx++, remaining--. Go to WRITE after the transfer that fills lane LANES-1 or makes remaining 0. Bubbles on px_valid are allowed.
- WRITE (exactly 1 cycle):
  - mem_we=1.
  - Lane k < filled: addr = (grp_addr+k) mod 2^AW, data = lane[k].
  - Unused lanes (partial last group): replicate the last filled lane's address and data. Duplicate same-address same-data writes are harmless.
  - Next cycle: grp_addr += LANES (mod 2^AW), lane_idx=0. Go to DONE if remaining==0, otherwise go to FILL.
- DONE: done=1 for one cycle, then go to IDLE. done and busy drop together.
- Address wrap: all address arithmetic is modulo 2^AW; no error flag.
- Throughput: a full group takes 10 FILL transfers + 1 WRITE, so 11 cycles minimum. Pixel k of a job is written at base_addr+k.
- start while busy=1 is ignored, not queued.
- abort: in any non-IDLE state, go to IDLE next cycle with no done pulse. If abort coincides with WRITE, that write still completes (mem_we already high). Pixels buffered in FILL are discarded.
- Asynchronous reset mid-job: immediate return to reset values, with no write issued.
- px_valid in IDLE/WRITE/DONE is ignored (px_ready=0).

Decomposition:
- Shared package dram_image_pkg holds LANES, AW, DW and the state enum (IDLE, FILL, WRITE, DONE), for reuse by future dramImage read sequencers.
- No sub-module: the lane buffer and FSM are small and tightly coupled.

Test Plan:
- Reset mid-FILL (assert rst_n=0 after 4 pixels): outputs go to 0 immediately, no mem_we; a new job then runs cleanly from lane 0.
- base=0, count=10, pixels 111..120 back-to-back: one mem_we cycle 10 cycles after the first transfer; lane k addr=k, data=111+k; done on the next cycle; busy low after.
- base=100, count=13, pixels 1..13 with random px_valid gaps: two writes. First write: addr 100..109, data 1..10. Second write: lanes 0-2 addr 110..112, data 11..13; lanes 3-9 addr 112, data 13. One done pulse.
- count=0: busy high 1 cycle, done pulse, mem_we never asserted, px_ready never asserted.
- base=262140, count=10: lane addresses 262140..262143, then 0..5.
- start asserted while busy: ignored (job parameters unchanged). abort after 5 pixels: IDLE next cycle, no mem_we, no done. abort during WRITE: the write occurs, no done pulse.
